// File: rtl/uart_transmitter_fsm.sv
// UART transmitter: start bit, 8 data bits LSB-first, even parity, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks. Frames repeat while Rxi is low,
// with at least one idle cycle between consecutive frames.
module uart_transmitter_fsm #(
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rxi,
  input  logic [7:0] UI,
  output logic       Txout
);

  localparam int unsigned TickW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             tick_last;

  assign tick_last = (tick_q == TickMax);
  assign Txout     = tx_q;

  // State, counters, data and line register; reset forces the line idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state and next line value; tx_d is what the line shows after this edge.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!Rxi) begin
          // UI is captured only here; later changes wait for the next frame.
          shift_d  = UI;
          parity_d = ^UI;
          tick_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
          tx_d     = 1'b0;
        end
      end

      StStart: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      StData: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StParity;
            tx_d    = parity_q;
          end else begin
            // Shift so the next bit to send is always at position 0.
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      StParity: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      StStop: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = StIdle;
          tx_d    = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter_fsm.sv
// Bench for uart_transmitter_fsm: per-cycle frame-level reference model, a table of
// data words with expected serial bits, and hand-written multi-cycle sequences.
module tb_uart_transmitter_fsm;

  localparam int unsigned C        = 2;
  localparam int          FrameLen = 11 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rxi;
  logic [7:0] UI;
  logic       Txout;

  int tests = 0;
  int fails = 0;

  // Reference model: position within an 11-bit frame, frame image built from the word.
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [10:0] m_frame  = '1;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] data;   // expected serial data bits, bit i sent i-th
    logic       par;
  } vec_t;

  vec_t vecs[5];

  uart_transmitter_fsm #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .Rxi   (Rxi),
    .UI    (UI),
    .Txout (Txout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic model_tx();
    return m_active ? m_frame[m_pos / C] : 1'b1;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, compare after it.
  task automatic cycle();
    logic       r  = Rxi;
    logic [7:0] u  = UI;
    logic       rs = rst;
    @(posedge clk);
    #1;
    if (rs || rst) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FrameLen) m_active = 1'b0;
    end else if (!r) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_frame  = {1'b1, ^u, u, 1'b0};
    end
    check("txout_model", Txout, model_tx());
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * FrameLen && m_active; i++) cycle();
  endtask

  // Send one frame of ui, Rxi raised right after the start edge; decode the line.
  task automatic run_frame(input vec_t v);
    logic s[FrameLen];
    Rxi = 1'b1;
    wait_idle();
    cycle();
    UI  = v.ui;
    Rxi = 1'b0;
    cycle();
    s[0] = Txout;
    Rxi  = 1'b1;
    for (int k = 1; k < FrameLen; k++) begin
      cycle();
      s[k] = Txout;
    end
    check("start_bit", s[C-1], 1'b0);
    for (int i = 0; i < 8; i++) check("data_bit", s[(i + 1) * C + C - 1], v.data[i]);
    check("parity_bit", s[9 * C + C - 1], v.par);
    check("stop_bit", s[10 * C + C - 1], 1'b1);
    for (int k = 0; k < 4; k++) cycle();
    check("idle_after_frame", Txout, 1'b1);
  endtask

  initial begin
    int starts[$];
    logic prev;

    vecs[0] = '{ui: 8'h00,        data: 8'b00000000, par: 1'b0};
    vecs[1] = '{ui: 8'b00111000, data: 8'b00111000, par: 1'b1};
    vecs[2] = '{ui: 8'b11110000, data: 8'b11110000, par: 1'b0};
    vecs[3] = '{ui: 8'b11101000, data: 8'b11101000, par: 1'b0};
    vecs[4] = '{ui: 8'b11001100, data: 8'b11001100, par: 1'b0};

    // Reset and quiet line with Rxi high.
    rst = 1'b1;
    Rxi = 1'b1;
    UI  = 8'hFF;
    #12;
    check("reset_txout", Txout, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i == 39) check("idle_40", Txout, 1'b1);
    end

    // Table of words: exact serial bits and parity.
    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back frames of 0x00: start edges every 11*C+1 cycles.
    UI   = 8'h00;
    Rxi  = 1'b0;
    prev = Txout;
    for (int i = 0; i < 3 * (FrameLen + 1) + 2; i++) begin
      cycle();
      if (prev === 1'b1 && Txout === 1'b0) starts.push_back(i);
      prev = Txout;
    end
    check("b2b_start_count", (starts.size() >= 3) ? 1'b1 : 1'b0, 1'b1);
    if (starts.size() >= 3) begin
      check("b2b_period_a", (starts[1] - starts[0] == 23) ? 1'b1 : 1'b0, 1'b1);
      check("b2b_period_b", (starts[2] - starts[1] == 23) ? 1'b1 : 1'b0, 1'b1);
    end

    // UI changed mid-frame: model holds the latched word, next frame takes the new one.
    Rxi = 1'b1;
    wait_idle();
    cycle();
    UI  = 8'hA5;
    Rxi = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    UI = 8'h3C;
    for (int i = 0; i < 2 * (FrameLen + 1); i++) cycle();
    // Rxi raised mid-frame: frame completes, then the line stays high.
    for (int i = 0; i < 5; i++) cycle();
    Rxi = 1'b1;
    for (int i = 0; i < FrameLen + 10; i++) cycle();
    check("stay_idle", Txout, 1'b1);

    // Asynchronous reset during DATA of a 0x00 frame.
    UI  = 8'h00;
    Rxi = 1'b0;
    for (int i = 0; i < C + 4; i++) cycle();
    check("in_data_low", Txout, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_txout", Txout, 1'b1);
    m_active = 1'b0;
    m_pos    = 0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 2 * (FrameLen + 1); i++) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      Rxi = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      UI  = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
